// File: rtl/be_pkg.sv
// ============================================================================
// be_pkg : ALU op / operand types, RV32I opcodes, issue-entry record
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package be_pkg;

   typedef enum logic [3:0] {
      ADD_alu    = 4'd0,
      SUB_alu    = 4'd1,
      SLL_alu    = 4'd2,
      SLT_alu    = 4'd3,
      SLTU_alu   = 4'd4,
      XOR_alu    = 4'd5,
      SRL_alu    = 4'd6,
      SRA_alu    = 4'd7,
      OR_alu     = 4'd8,
      AND_alu    = 4'd9,
      PASS_B_alu = 4'd10
   } RV32I_ALU_OP_t;

   typedef logic [31:0] RV32I_OPERAND_t;

   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;
   localparam logic [6:0] c_opc_branch = 7'b1100011;

   typedef struct packed {
      RV32I_ALU_OP_t  op;
      RV32I_OPERAND_t a;
      RV32I_OPERAND_t b;
      logic [31:0]    pc;
      logic           illegal;
   } issue_entry_t;

   // alt selects SUB on funct3=000 and SRA on funct3=101
   function automatic RV32I_ALU_OP_t alu_from_f3(input logic [2:0] f3, input logic alt);
      RV32I_ALU_OP_t op;
      case (f3)
         3'b000:  op = alt ? SUB_alu : ADD_alu;
         3'b001:  op = SLL_alu;
         3'b010:  op = SLT_alu;
         3'b011:  op = SLTU_alu;
         3'b100:  op = XOR_alu;
         3'b101:  op = alt ? SRA_alu : SRL_alu;
         3'b110:  op = OR_alu;
         default: op = AND_alu;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_alu_issue_decode.sv
// ============================================================================
// rv32i_alu_issue_decode : combinational RV32I instruction -> issue entry
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rv32i_alu_issue_decode
   import be_pkg::*;
(
   input  logic [31:0]  instr,
   input  logic [31:0]  pc,
   input  logic [31:0]  rs1,
   input  logic [31:0]  rs2,
   output issue_entry_t entry
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_u;
   logic [31:0] w_shamt;

   assign w_opc   = instr[6:0];
   assign w_f3    = instr[14:12];
   assign w_f7    = instr[31:25];
   assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
   assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign w_imm_u = {instr[31:12], 12'h000};
   assign w_shamt = {27'd0, instr[24:20]};

   always_comb begin
      entry.op      = ADD_alu;
      entry.a       = '0;
      entry.b       = '0;
      entry.pc      = pc;
      entry.illegal = 1'b0;
      case (w_opc)
         c_opc_op: begin
            entry.op      = alu_from_f3(w_f3, w_f7[5]);
            entry.a       = rs1;
            entry.b       = rs2;
            entry.illegal = !((w_f7 == 7'h00) ||
                              ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
         end
         c_opc_op_imm: begin
            // instr[30] only means SRAI on funct3=101; on ADDI it is immediate data
            entry.op = alu_from_f3(w_f3, (w_f3 == 3'b101) && instr[30]);
            entry.a  = rs1;
            entry.b  = w_imm_i;
            if (w_f3 == 3'b001) begin
               entry.b       = w_shamt;
               entry.illegal = (w_f7 != 7'h00);
            end else if (w_f3 == 3'b101) begin
               entry.b       = w_shamt;
               entry.illegal = (w_f7 != 7'h00) && (w_f7 != 7'h20);
            end
         end
         c_opc_lui: begin
            entry.op = PASS_B_alu;
            entry.b  = w_imm_u;
         end
         c_opc_auipc: begin
            entry.a = pc;
            entry.b = w_imm_u;
         end
         c_opc_load: begin
            entry.a = rs1;
            entry.b = w_imm_i;
         end
         c_opc_store: begin
            entry.a = rs1;
            entry.b = w_imm_s;
         end
         c_opc_jal, c_opc_jalr: begin
            entry.a = pc;
            entry.b = 32'd4;
         end
         c_opc_branch: begin
            entry.a = rs1;
            entry.b = rs2;
            case (w_f3)
               3'b000, 3'b001: entry.op = SUB_alu;
               3'b100, 3'b101: entry.op = SLT_alu;
               3'b110, 3'b111: entry.op = SLTU_alu;
               default: begin
                  entry.op      = SUB_alu;
                  entry.illegal = 1'b1;
               end
            endcase
         end
         default: entry.illegal = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rv32i_alu_issue.sv
// ============================================================================
// rv32i_alu_issue : issue-stage handshake/storage; RV32I_ISSUE_SKID_BUFFER_EN
// selects a 2-entry skid buffer with registered in_ready.   Rev 1.0
// ============================================================================
`default_nettype none

module rv32i_alu_issue
   import be_pkg::*;
#(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_PC_VAL = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic           out_valid,
   input  logic           out_ready,
   output RV32I_ALU_OP_t  out_alu_op,
   output RV32I_OPERAND_t out_a,
   output RV32I_OPERAND_t out_b,
   output logic [XLEN-1:0] out_pc,
   output logic           out_illegal
);

   localparam issue_entry_t c_reset_entry = '{op: ADD_alu, a: '0, b: '0,
                                              pc: RESET_PC_VAL, illegal: 1'b0};

   issue_entry_t w_dec_entry;
   issue_entry_t main_d, main_q;
   logic         main_valid_d, main_valid_q;
   logic         w_accept;
   logic         w_drain;

   rv32i_alu_issue_decode u_decode (
      .instr (in_instr),
      .pc    (in_pc),
      .rs1   (in_rs1),
      .rs2   (in_rs2),
      .entry (w_dec_entry)
   );

   assign w_accept    = in_valid && in_ready;
   assign w_drain     = main_valid_q && out_ready;

   assign out_valid   = main_valid_q;
   assign out_alu_op  = main_q.op;
   assign out_a       = main_q.a;
   assign out_b       = main_q.b;
   assign out_pc      = main_q.pc;
   assign out_illegal = main_q.illegal;

`ifdef RV32I_ISSUE_SKID_BUFFER_EN
   issue_entry_t skid_d, skid_q;
   logic         skid_valid_d, skid_valid_q;
   logic         in_ready_d, in_ready_q;

   assign in_ready = in_ready_q;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      // skid is only ever occupied while main is, so it refills main first
      if (!main_valid_q || w_drain) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (w_accept) begin
            main_d       = w_dec_entry;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (w_accept) begin
         skid_d       = w_dec_entry;
         skid_valid_d = 1'b1;
      end
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= c_reset_entry;
         main_valid_q <= 1'b0;
         skid_q       <= c_reset_entry;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   assign in_ready = !main_valid_q || out_ready;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      if (w_accept) begin
         main_d       = w_dec_entry;
         main_valid_d = 1'b1;
      end else if (w_drain) begin
         main_valid_d = 1'b0;
      end
      if (flush) begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= c_reset_entry;
         main_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32i_alu_issue.sv
// ============================================================================
// tb_rv32i_alu_issue : directed vector bench for rv32i_alu_issue
// (expectations follow RV32I_ISSUE_SKID_BUFFER_EN when defined).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_alu_issue;
   import be_pkg::*;

`ifdef RV32I_ISSUE_SKID_BUFFER_EN
   localparam int c_exp_accepted = 2;
`else
   localparam int c_exp_accepted = 1;
`endif
   localparam logic [31:0] c_reset_pc = 32'hABCD_0000;

   logic           clk = 1'b0;
   logic           rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0]    in_instr, in_pc, in_rs1, in_rs2, out_pc;
   RV32I_ALU_OP_t  out_alu_op;
   RV32I_OPERAND_t out_a, out_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32i_alu_issue #(.XLEN(32), .RESET_PC_VAL(c_reset_pc)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
      .out_a(out_a), .out_b(out_b), .out_pc(out_pc), .out_illegal(out_illegal)
   );

   typedef struct {
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [31:0]   rs1;
      logic [31:0]   rs2;
      RV32I_ALU_OP_t op;
      logic [31:0]   a;
      logic [31:0]   b;
      logic          ill;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      in_instr = v.instr;
      in_pc    = v.pc;
      in_rs1   = v.rs1;
      in_rs2   = v.rs2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_op"}, 32'(out_alu_op), 32'(ADD_alu));
      chk({tag, "_a"}, out_a, 32'd0);
      chk({tag, "_b"}, out_b, 32'd0);
      chk({tag, "_pc"}, out_pc, c_reset_pc);
      chk({tag, "_illegal"}, 32'(out_illegal), 32'd0);
   endtask

   // hold out_ready low and present the same instruction for n cycles
   task automatic fill(input int n);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(tbl[0]);
      repeat (n) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepted;
      logic rdy;

      tbl[0]  = '{32'h002081B3, 32'h100, 32'd5,     32'd7,    ADD_alu,    32'd5,     32'd7,        1'b0};
      tbl[1]  = '{32'h402081B3, 32'h104, 32'd5,     32'd7,    SUB_alu,    32'd5,     32'd7,        1'b0};
      tbl[2]  = '{32'hFFF00093, 32'h108, 32'd9,     32'd0,    ADD_alu,    32'd9,     32'hFFFFFFFF, 1'b0};
      tbl[3]  = '{32'h123450B7, 32'h10C, 32'h33,    32'h44,   PASS_B_alu, 32'd0,     32'h12345000, 1'b0};
      tbl[4]  = '{32'h4030D093, 32'h110, 32'h80,    32'd0,    SRA_alu,    32'h80,    32'd3,        1'b0};
      tbl[5]  = '{32'h00001297, 32'h200, 32'h1,     32'h2,    ADD_alu,    32'h200,   32'h1000,     1'b0};
      tbl[6]  = '{32'hFFC0A283, 32'h204, 32'h1000,  32'h2,    ADD_alu,    32'h1000,  32'hFFFFFFFC, 1'b0};
      tbl[7]  = '{32'h0020A423, 32'h208, 32'h2000,  32'h55,   ADD_alu,    32'h2000,  32'd8,        1'b0};
      tbl[8]  = '{32'h008000EF, 32'h20C, 32'h1,     32'h2,    ADD_alu,    32'h20C,   32'd4,        1'b0};
      tbl[9]  = '{32'h00208063, 32'h210, 32'd3,     32'd4,    SUB_alu,    32'd3,     32'd4,        1'b0};
      tbl[10] = '{32'h0020E063, 32'h214, 32'd3,     32'd4,    SLTU_alu,   32'd3,     32'd4,        1'b0};
      tbl[11] = '{32'h0000007F, 32'h218, 32'h11,    32'h22,   ADD_alu,    32'd0,     32'd0,        1'b1};
      tbl[12] = '{32'h4020C1B3, 32'h21C, 32'd6,     32'd9,    XOR_alu,    32'd6,     32'd9,        1'b1};
      tbl[13] = '{32'h40109093, 32'h220, 32'd6,     32'd9,    SLL_alu,    32'd6,     32'd1,        1'b1};
      tbl[14] = '{32'h0020C1B3, 32'h224, 32'd6,     32'd9,    XOR_alu,    32'd6,     32'd9,        1'b0};
      tbl[15] = '{32'hFFF0B093, 32'h228, 32'd6,     32'd9,    SLTU_alu,   32'd6,     32'hFFFFFFFF, 1'b0};
      tbl[16] = '{32'h0020C063, 32'h22C, 32'd3,     32'd4,    SLT_alu,    32'd3,     32'd4,        1'b0};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(tbl[0]);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk_reset_state("reset");

      // back-to-back stream, one instruction per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         drive(tbl[i]);
         #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_op", i), 32'(out_alu_op), 32'(tbl[i].op));
         chk($sformatf("v%0d_a", i), out_a, tbl[i].a);
         chk($sformatf("v%0d_b", i), out_b, tbl[i].b);
         chk($sformatf("v%0d_pc", i), out_pc, tbl[i].pc);
         chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(tbl[i].ill));
      end
      in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // backpressure: offer three instructions while the ALU stalls
      out_ready = 1'b0;
      accepted  = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         drive(tbl[accepted < 3 ? accepted : 2]);
         #1 rdy = in_ready;
         tick();
         if (rdy) accepted++;
      end
      in_valid = 1'b0;
      chk("stall_accepted", 32'(accepted), 32'(c_exp_accepted));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_op", 32'(out_alu_op), 32'(ADD_alu));
      chk("stall_hold_a", out_a, 32'd5);
      chk("stall_hold_pc", out_pc, 32'h100);
      out_ready = 1'b1;
      tick();
`ifdef RV32I_ISSUE_SKID_BUFFER_EN
      chk("release_second_valid", 32'(out_valid), 32'd1);
      chk("release_second_op", 32'(out_alu_op), 32'(SUB_alu));
      chk("release_second_pc", out_pc, 32'h104);
      tick();
`endif
      chk("release_empty", 32'(out_valid), 32'd0);

      // flush with the buffer full and a new instruction offered
      fill(3);
      flush = 1'b1;
      in_valid = 1'b1;
      drive(tbl[3]);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("flush_nothing1", 32'(out_valid), 32'd0);
      tick();
      chk("flush_nothing2", 32'(out_valid), 32'd0);

      // flush while empty: the same-cycle accept must be dropped
      out_ready = 1'b1;
      flush = 1'b1; in_valid = 1'b1;
      drive(tbl[4]);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_accept_dropped", 32'(out_valid), 32'd0);

      // reset with entries held
      fill(3);
      rst = 1'b1; in_valid = 1'b1;
      drive(tbl[5]);
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk_reset_state("midrst");
      out_ready = 1'b1;
      tick();
      chk("midrst_nothing", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rv32i_alu_issue.md
Name: rv32i_alu_issue

Overview:
- Issue stage that feeds the back-end ALU.
- Accepts a fetched RV32I instruction plus its register operands and PC, decodes opcode/funct3/funct7 into a `be_pkg` ALU op, and performs all A/B operand muxing, including immediate generation.
- Presents registered `alu_op`, `a` and `b` to the execute stage over a valid/ready handshake.
- Sits between register-file read and the ALU.

Parameters:
- XLEN, 32, operand and instruction width.
- RESET_PC_VAL, 32'h0000_0000, value driven on `out_pc` after reset (debug visibility only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- in_rs1  in  XLEN  rs1 register value.
- in_rs2  in  XLEN  rs2 register value.
- out_valid  out  1  issued entry is valid.
- out_ready  in  1  ALU/execute accepts this cycle.
- out_alu_op  out  RV32I_ALU_OP_t  decoded operation.
- out_a  out  RV32I_OPERAND_t  operand A.
- out_b  out  RV32I_OPERAND_t  operand B.
- out_pc  out  XLEN  PC of the issued entry.
- out_illegal  out  1  unsupported encoding; ALU result must be discarded.

Behaviour:
- Reset values: `out_valid`=0, `out_alu_op`=ADD_alu, `out_a`=0, `out_b`=0, `out_pc`=RESET_PC_VAL, `out_illegal`=0. `in_ready`=1 in the cycle after reset releases.
- Transfer occurs on valid&ready, on either side. Latency: an accepted instruction appears on `out_*` the next cycle.
- `out_*` must stay stable while `out_valid`=1 and `out_ready`=0.
- Decode by opcode:
  - OP (0110011): A=rs1, B=rs2. Op from funct3; funct7[5] selects SUB/SRA. funct7 other than 0x00/0x20, or 0x20 with funct3 not in {000,101}, sets illegal.
  - OP-IMM (0010011): A=rs1, B=sext(I-imm).
    - SLLI/SRLI/SRAI: B=zext(shamt).
    - SRAI is selected by instr[30].
    - instr[31:25] other than 0x00, or 0x20 for SRxI, sets illegal.
  - LUI: op PASS_B, A=0, B=U-imm. AUIPC: ADD, A=pc, B=U-imm.
  - LOAD: ADD, rs1 + sext(I-imm). STORE: ADD, rs1 + sext(S-imm).
  - JAL/JALR: ADD, A=pc, B=4 (link value).
  - BRANCH: SUB for BEQ/BNE; SLT for BLT/BGE; SLTU for BLTU/BGEU. A=rs1, B=rs2.
  - Any other opcode: illegal=1, op ADD_alu, A=B=0.
- Illegal entries still travel the handshake; they are never dropped.
- Buffering: 2-entry skid (main + skid register).
  - `in_ready` is a registered signal, equal to "skid entry empty".
  - Accept while `out_valid`=1 and `out_ready`=0 → the new entry goes to skid.
  - When main drains, skid moves to main in the same edge. Order is preserved; throughput is 1/cycle.
- Full: both entries held → `in_ready`=0. A simultaneous `out_ready` in that cycle frees skid on the next edge.
- flush: next edge clears both valids and sets `in_ready`=1. A same-cycle accept is discarded. flush has priority over all other events.
- rst mid-transfer: identical to flush, plus the output registers return to their reset values.

Optional Feature:
- Macro: RV32I_ISSUE_SKID_BUFFER_EN.
- Defined: 2-entry skid behaviour as above; no combinational path from `out_ready` to `in_ready`.
- Undefined: single output register. `in_ready` = !out_valid | out_ready (combinational). Same latency and throughput.

Decomposition:
- `be_pkg` holds:
  - RV32I_ALU_OP_t, extended with SUB_alu, SLL_alu, SLT_alu, SLTU_alu, XOR_alu, SRL_alu, SRA_alu, OR_alu, AND_alu, PASS_B_alu.
  - RV32I_OPERAND_t.
  - Opcode constants.
  - A packed issue-entry struct {op, a, b, pc, illegal}.
- Sub-module `rv32i_alu_issue_decode`: purely combinational instruction → issue-entry. The top level contains only handshake and storage.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op=ADD_alu, a=5, b=7, illegal=0.
- Back-to-back 0x402081B3 (sub) then 0xFFF00093 (addi x1,x0,-1) → SUB_alu a=5,b=7; then ADD_alu a=rs1, b=0xFFFFFFFF. No bubbles.
- 0x123450B7 (lui), then 0x4030D093 (srai x1,x1,3) → PASS_B_alu b=0x12345000; then SRA_alu b=3.
- Hold out_ready=0 and issue 3 instructions:
  - With the macro: 2 accepted, then in_ready=0; release → both emerge in order.
  - Without the macro: 1 accepted.
- Opcode 0x7F (0x0000007F) → out_illegal=1, op=ADD_alu, a=b=0; still requires the out handshake.
- Assert flush with 2 entries held and in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emerges. Repeat with rst → outputs at reset values.
